rc_channel_decoder: RTL and testbench

- Downstream consumer of the pulse-width measurement stage.
- Takes each measured RC servo pulse length (in prescaled ticks, nominally µs) with its strobe and ready flag.
- Validates it, converts it to a signed stick value centred on neutral, applies a deadband, saturation and a moving-average filter, and supervises link health with a failsafe state machine.
- Output feeds the motor mixer as a signed 10-bit command plus a valid flag.

---
 rtl/rc_channel_decoder_pkg.sv | 15 +
 rtl/rc_channel_decoder_avg_filter.sv | 50 +++++
 rtl/rc_channel_decoder.sv | 166 ++++++++++++++++
 tb/tb_rc_channel_decoder.sv | 179 +++++++++++++++++
 4 files changed

// File: rtl/rc_channel_decoder_pkg.sv
// Shared definitions for the RC channel decoder: command width, range limits and
// the link-supervision state encoding used by the motor mixer as well.
package rc_channel_decoder_pkg;

    localparam int VAL_W   = 10;
    localparam int VAL_MAX = 511;
    localparam int VAL_MIN = -512;

    typedef enum logic [1:0] {
        ST_FAILSAFE = 2'd0,
        ST_ARMING   = 2'd1,
        ST_RUN      = 2'd2
    } rc_state_e;

endpackage

// File: rtl/rc_channel_decoder_avg_filter.sv
// Moving-average filter: circular history plus running sum. The next average is
// presented combinationally so the owner can register it in the same cycle.
module rc_avg_filter
    import rc_channel_decoder_pkg::*;
#(
    parameter int AVG_LOG2 = 2
) (
    input  logic                    clk,
    input  logic                    reset_n,
    input  logic                    i_load,
    input  logic                    i_upd,
    input  logic signed [VAL_W-1:0] i_val,
    output logic signed [VAL_W-1:0] o_avg_nxt
);

    localparam int DEPTH  = 1 << AVG_LOG2;
    localparam int SUM_W  = VAL_W + AVG_LOG2;
    localparam int PW     = (AVG_LOG2 > 0) ? AVG_LOG2 : 1;
    localparam int HSLOTS = 1 << PW;
    localparam logic [PW-1:0] PTR_LAST = PW'(DEPTH - 1);

    logic signed [VAL_W-1:0] r_hist [HSLOTS];
    logic signed [SUM_W-1:0] r_sum;
    logic        [PW-1:0]    r_ptr;

    logic signed [SUM_W-1:0] w_sum_upd, w_sum_load, w_sum_nxt;

    // Running sum swaps the oldest slot for the new sample; a load fills every slot.
    assign w_sum_upd  = r_sum + SUM_W'(i_val) - SUM_W'(r_hist[r_ptr]);
    assign w_sum_load = SUM_W'(i_val) <<< AVG_LOG2;
    assign w_sum_nxt  = i_load ? w_sum_load : w_sum_upd;
    assign o_avg_nxt  = VAL_W'(w_sum_nxt >>> AVG_LOG2);

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            for (int k = 0; k < HSLOTS; k++) r_hist[k] <= '0;
            r_sum <= '0;
            r_ptr <= '0;
        end else if (i_load) begin
            for (int k = 0; k < HSLOTS; k++) r_hist[k] <= i_val;
            r_sum <= w_sum_load;
            r_ptr <= '0;
        end else if (i_upd) begin
            r_hist[r_ptr] <= i_val;
            r_sum         <= w_sum_upd;
            r_ptr         <= (r_ptr == PTR_LAST) ? '0 : r_ptr + 1'b1;
        end
    end

endmodule

// File: rtl/rc_channel_decoder.sv
// RC servo pulse decoder: validate, centre, deadband/clamp, average, and supervise
// link health with a failsafe FSM. Fixed 3-cycle latency from in_stb to value_stb.
module rc_channel_decoder
    import rc_channel_decoder_pkg::*;
#(
    parameter int IN_W        = 17,
    parameter int CENTER      = 1500,
    parameter int MIN_VALID   = 800,
    parameter int MAX_VALID   = 2200,
    parameter int DEADBAND    = 10,
    parameter int AVG_LOG2    = 2,
    parameter int BAD_LIMIT   = 3,
    parameter int ARM_SAMPLES = 2,
    parameter int TIMEOUT_CYC = 2500000
) (
    input  logic                    clk,
    input  logic                    reset_n,
    input  logic                    in_stb,
    input  logic                    in_ready,
    input  logic [IN_W-1:0]         in_length,
    output logic signed [VAL_W-1:0] value,
    output logic                    value_stb,
    output logic                    valid,
    output logic                    failsafe
);

    localparam int DW    = IN_W + 1;
    localparam int WD_W  = $clog2(TIMEOUT_CYC + 1);
    localparam int ARM_W = $clog2(ARM_SAMPLES + 1);
    localparam int BAD_W = $clog2(BAD_LIMIT + 1);

    localparam logic [IN_W-1:0]      MIN_L    = IN_W'(MIN_VALID);
    localparam logic [IN_W-1:0]      MAX_L    = IN_W'(MAX_VALID);
    localparam logic signed [DW-1:0] CENTER_D = DW'(CENTER);
    localparam logic signed [DW-1:0] DB_D     = DW'(DEADBAND);
    localparam logic signed [DW-1:0] VMAX_D   = DW'(VAL_MAX);
    localparam logic signed [DW-1:0] VMIN_D   = DW'(VAL_MIN);
    localparam logic [WD_W-1:0]      TO_L     = WD_W'(TIMEOUT_CYC);
    localparam logic [ARM_W-1:0]     ARM_L    = ARM_W'(ARM_SAMPLES);
    localparam logic [BAD_W-1:0]     BAD_L    = BAD_W'(BAD_LIMIT);

    // Stage valid/good shift registers: [0] = S1, [1] = S2.
    logic [1:0]              r_vld_pipe, r_good_pipe;
    logic signed [DW-1:0]    r_s1_diff;
    logic signed [VAL_W-1:0] r_s2_val;

    logic                    w_in_good;
    logic signed [DW-1:0]    w_diff, w_abs;
    logic signed [VAL_W-1:0] w_s2_val, w_avg_nxt;

    assign w_in_good = in_ready && (in_length >= MIN_L) && (in_length <= MAX_L);
    assign w_diff    = $signed({1'b0, in_length}) - CENTER_D;
    assign w_abs     = r_s1_diff[DW-1] ? -r_s1_diff : r_s1_diff;

    always_comb begin
        w_s2_val = '0;
        if (w_abs < DB_D)           w_s2_val = '0;
        else if (r_s1_diff > VMAX_D) w_s2_val = VAL_W'(VAL_MAX);
        else if (r_s1_diff < VMIN_D) w_s2_val = VAL_W'(VAL_MIN);
        else                         w_s2_val = r_s1_diff[VAL_W-1:0];
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_vld_pipe  <= '0;
            r_good_pipe <= '0;
            r_s1_diff   <= '0;
            r_s2_val    <= '0;
        end else begin
            r_vld_pipe  <= {r_vld_pipe[0], in_stb};
            r_good_pipe <= {r_good_pipe[0], in_stb & w_in_good};
            r_s1_diff   <= w_diff;
            r_s2_val    <= w_s2_val;
        end
    end

    // Watchdog: a good sample sitting in S1 wins over a terminal count that cycle.
    logic [WD_W-1:0] r_wd, w_wd_nxt;
    logic            w_tmo;

    assign w_wd_nxt = (r_vld_pipe[0] && r_good_pipe[0]) ? '0 :
                      (r_wd == TO_L)                     ? r_wd : r_wd + 1'b1;
    assign w_tmo    = (w_wd_nxt == TO_L);

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) r_wd <= '0;
        else          r_wd <= w_wd_nxt;
    end

    rc_state_e        r_state;
    logic [ARM_W-1:0] r_arm, w_arm_inc;
    logic [BAD_W-1:0] r_bad, w_bad_inc;
    logic             w_s3_good, w_s3_bad, w_arm_done, w_bad_trip;
    logic             w_flt_load, w_flt_upd;

    assign w_s3_good  = r_vld_pipe[1] & r_good_pipe[1];
    assign w_s3_bad   = r_vld_pipe[1] & ~r_good_pipe[1];
    assign w_arm_inc  = r_arm + 1'b1;
    assign w_bad_inc  = (r_bad == BAD_L) ? r_bad : r_bad + 1'b1;
    assign w_arm_done = w_s3_good && (w_arm_inc == ARM_L);
    assign w_bad_trip = w_s3_bad && (w_bad_inc >= BAD_L);
    assign w_flt_load = (r_state != ST_RUN) && w_arm_done;
    assign w_flt_upd  = (r_state == ST_RUN) && w_s3_good && !w_tmo;

    rc_avg_filter #(.AVG_LOG2(AVG_LOG2)) u_avg (
        .clk       (clk),
        .reset_n   (reset_n),
        .i_load    (w_flt_load),
        .i_upd     (w_flt_upd),
        .i_val     (r_s2_val),
        .o_avg_nxt (w_avg_nxt)
    );

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state   <= ST_FAILSAFE;
            r_arm     <= '0;
            r_bad     <= '0;
            value     <= '0;
            value_stb <= 1'b0;
            valid     <= 1'b0;
            failsafe  <= 1'b1;
        end else begin
            value_stb <= 1'b0;
            case (r_state)
                ST_FAILSAFE, ST_ARMING: begin
                    if (w_arm_done) begin
                        r_state   <= ST_RUN;
                        r_arm     <= '0;
                        r_bad     <= '0;
                        value     <= r_s2_val;
                        value_stb <= 1'b1;
                        valid     <= 1'b1;
                        failsafe  <= 1'b0;
                    end else if (w_s3_good) begin
                        r_arm   <= w_arm_inc;
                        r_state <= ST_ARMING;
                    end else if (r_state == ST_ARMING && (w_s3_bad || w_tmo)) begin
                        r_arm   <= '0;
                        r_state <= ST_FAILSAFE;
                    end
                end
                ST_RUN: begin
                    // Bad-limit and timeout together still make a single entry.
                    if (w_bad_trip || w_tmo) begin
                        r_state   <= ST_FAILSAFE;
                        r_arm     <= '0;
                        r_bad     <= '0;
                        value     <= '0;
                        value_stb <= 1'b1;
                        valid     <= 1'b0;
                        failsafe  <= 1'b1;
                    end else if (w_s3_good) begin
                        value     <= w_avg_nxt;
                        value_stb <= 1'b1;
                        r_bad     <= '0;
                    end else if (w_s3_bad) begin
                        r_bad <= w_bad_inc;
                    end
                end
                default: r_state <= ST_FAILSAFE;
            endcase
        end
    end

endmodule

// File: tb/tb_rc_channel_decoder.sv
// Randomised bench for rc_channel_decoder against a sample-level reference model.
module tb_rc_channel_decoder;

    localparam int T_CYC = 1000;

    logic               clk = 1'b0;
    logic               reset_n = 1'b0;
    logic               in_stb = 1'b0;
    logic               in_ready = 1'b0;
    logic [16:0]        in_length = '0;
    logic signed [9:0]  value;
    logic               value_stb, valid, failsafe;

    int errs = 0;
    int checks = 0;

    always #5 clk = ~clk;

    rc_channel_decoder #(
        .IN_W(17), .CENTER(1500), .MIN_VALID(800), .MAX_VALID(2200), .DEADBAND(10),
        .AVG_LOG2(2), .BAD_LIMIT(3), .ARM_SAMPLES(2), .TIMEOUT_CYC(T_CYC)
    ) dut (
        .clk(clk), .reset_n(reset_n), .in_stb(in_stb), .in_ready(in_ready),
        .in_length(in_length), .value(value), .value_stb(value_stb),
        .valid(valid), .failsafe(failsafe)
    );

    task automatic chk(input string tag, input int act, input int exp);
        checks++;
        if (act !== exp) begin
            errs++;
            $display("FAIL %s: got %0d expected %0d at %0t", tag, act, exp, $time);
        end
    endtask

    // Reference model: 0 = failsafe, 1 = arming, 2 = run
    int  m_state, m_arm, m_bad, m_wd, m_val;
    bit  m_stb;
    bit  p_v[2], p_g[2];
    int  p_s[2];
    int  m_hist[$];
    bit  m_tmo, m_pv, m_pg, m_trip;
    int  m_ps;

    function automatic int shape(input int len);
        int d;
        d = len - 1500;
        if (d < 10 && d > -10) return 0;
        if (d > 511) return 511;
        if (d < -512) return -512;
        return d;
    endfunction

    function automatic int avg_hist();
        int s, q;
        s = 0;
        foreach (m_hist[k]) s += m_hist[k];
        q = s / 4;
        if (s < 0 && q * 4 != s) q--;
        return q;
    endfunction

    always @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            m_state = 0; m_arm = 0; m_bad = 0; m_wd = 0; m_val = 0; m_stb = 0;
            p_v[0] = 0; p_v[1] = 0; p_g[0] = 0; p_g[1] = 0;
            m_hist = {0, 0, 0, 0};
        end else begin
            if (p_v[0] && p_g[0]) begin
                m_wd = 0; m_tmo = 0;
            end else begin
                if (m_wd < T_CYC) m_wd++;
                m_tmo = (m_wd == T_CYC);
            end
            m_pv = p_v[1]; m_pg = p_g[1]; m_ps = p_s[1];
            p_v[1] = p_v[0]; p_g[1] = p_g[0]; p_s[1] = p_s[0];
            p_v[0] = in_stb;
            p_g[0] = in_ready && in_length >= 800 && in_length <= 2200;
            p_s[0] = shape(int'(in_length));
            m_stb = 0;
            if (m_state != 2) begin
                if (m_pv && m_pg) begin
                    m_arm++;
                    if (m_arm == 2) begin
                        m_hist = {m_ps, m_ps, m_ps, m_ps};
                        m_val = m_ps; m_stb = 1; m_state = 2; m_arm = 0; m_bad = 0;
                    end else m_state = 1;
                end else if (m_state == 1 && (m_pv || m_tmo)) begin
                    m_arm = 0; m_state = 0;
                end
            end else begin
                m_trip = m_tmo;
                if (m_pv && !m_pg) begin
                    if (m_bad < 3) m_bad++;
                    if (m_bad >= 3) m_trip = 1;
                end
                if (m_trip) begin
                    m_state = 0; m_val = 0; m_stb = 1; m_bad = 0; m_arm = 0;
                end else if (m_pv && m_pg) begin
                    m_hist.push_back(m_ps);
                    void'(m_hist.pop_front());
                    m_val = avg_hist(); m_stb = 1; m_bad = 0;
                end
            end
        end
    end

    always @(negedge clk) begin
        chk("value_stb", int'(value_stb), int'(m_stb));
        chk("valid", int'(valid), int'(m_state == 2));
        chk("failsafe", int'(failsafe), int'(m_state != 2));
        chk("value", int'(value), m_val);
    end

    // Called at a negedge; strobe is sampled on the following posedge.
    task automatic pulse(input int len, input bit rdy, input int gap);
        in_stb = 1'b1; in_ready = rdy; in_length = 17'(len);
        @(negedge clk);
        in_stb = 1'b0;
        repeat (gap) @(negedge clk);
    endtask

    task automatic async_reset();
        @(posedge clk);
        #2 reset_n = 1'b0;
        #1;
        chk("rst_value", int'(value), 0);
        chk("rst_stb", int'(value_stb), 0);
        chk("rst_valid", int'(valid), 0);
        chk("rst_failsafe", int'(failsafe), 1);
        @(negedge clk);
        #1 reset_n = 1'b1;
        @(negedge clk);
    endtask

    initial begin
        int db_vals[4];
        db_vals = '{1505, 1490, 2100, 900};
        repeat (3) @(negedge clk);
        reset_n = 1'b1;
        repeat (2) @(negedge clk);

        pulse(1500, 1, 4);
        pulse(1500, 1, 5);
        repeat (4) pulse(1700, 1, 3);
        foreach (db_vals[i]) pulse(db_vals[i], 1, 3);

        foreach (db_vals[i]) begin
            pulse(1500, 0, 1); pulse(2300, 1, 0); pulse(1500, 0, 4);
            pulse(db_vals[i], 1, 0); pulse(db_vals[i], 1, 4);
        end

        pulse(2300, 1, 1); pulse(1500, 0, 1); pulse(1600, 1, 4);
        pulse(700, 1, 0); pulse(1500, 0, 0); pulse(1650, 1, 4);

        repeat (T_CYC + 20) @(negedge clk);
        pulse(1500, 1, 0); pulse(1500, 1, 999);
        pulse(1550, 1, 1000);
        pulse(1560, 1, 5);
        pulse(1500, 1, T_CYC + 5);
        pulse(1500, 1, 0); pulse(1520, 1, 1500);

        pulse(1500, 1, 0); pulse(1500, 1, 4);
        pulse(1600, 1, 0); pulse(1700, 1, 0);
        async_reset();
        pulse(1500, 1, 5);
        pulse(1500, 1, 5);

        for (int n = 0; n < 400; n++) begin
            if ($urandom_range(0, 149) == 0) async_reset();
            pulse($urandom_range(700, 2400), $urandom_range(0, 9) != 0, $urandom_range(0, 3));
        end
        repeat (6) @(negedge clk);

        $display("Result: errors=%0d of %0d checks", errs, checks);
        $finish;
    end

endmodule
